// File: rtl/row_transfer_ctrl.sv
// row_transfer_ctrl: sequences one frame through the row cache.
// Each row is loaded from SDRAM into the row cache (image_width beats), handed
// to the window engine, and the processed row (image_width-1 beats) is written
// back to SDRAM before moving on to the next row.
// Optional feature: define TRANSFER_TIMEOUT_EN to add an 8-bit stall watchdog
// that parks the block in a sticky ERR state (left only through rst).
module row_transfer_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [12:0] image_width,
  input  logic [12:0] image_height,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        sram_mode,
  output logic        sdram_mode,
  output logic        update,
  output logic        start_flag,
  output logic        row_ready,
  input  logic        row_done,
  output logic        busy,
  output logic        frame_done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    LOAD      = 3'd2,
    WAIT_PROC = 3'd3,
    STORE     = 3'd4,
    NEXT      = 3'd5,
    DONE      = 3'd6
`ifdef TRANSFER_TIMEOUT_EN
    , ERR     = 3'd7
`endif
  } state_t;

  state_t      state;
  logic [12:0] width_q;
  logic [12:0] height_q;
  logic [12:0] row_cnt;
  logic [12:0] beat_cnt;

`ifdef TRANSFER_TIMEOUT_EN
  logic [7:0]  wd_cnt;
`else
  assign err = 1'b0;
`endif

  // Frame sequencer: state, counters and every registered output move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      width_q    <= 13'd0;
      height_q   <= 13'd0;
      row_cnt    <= 13'd0;
      beat_cnt   <= 13'd0;
      mem_req    <= 1'b0;
      update     <= 1'b0;
      start_flag <= 1'b0;
      row_ready  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sram_mode  <= 1'b1;
      sdram_mode <= 1'b1;
`ifdef TRANSFER_TIMEOUT_EN
      err        <= 1'b0;
      wd_cnt     <= 8'd0;
`endif
    end else begin
      // An address step follows every beat the memory accepted last cycle.
      update     <= mem_req & mem_ack;
      start_flag <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          // Degenerate frames (no store beats or no rows) are simply not started.
          if (start && (image_width >= 13'd2) && (image_height != 13'd0)) begin
            width_q    <= image_width;
            height_q   <= image_height;
            start_flag <= 1'b1;
            busy       <= 1'b1;
            state      <= INIT;
          end
        end

        INIT: begin
          row_cnt  <= 13'd0;
          beat_cnt <= 13'd0;
          mem_req  <= 1'b1;
          state    <= LOAD;
        end

        LOAD: begin
          if (mem_ack) begin
            if (beat_cnt == width_q - 13'd1) begin
              beat_cnt   <= 13'd0;
              mem_req    <= 1'b0;
              row_ready  <= 1'b1;
              sram_mode  <= 1'b0;
              sdram_mode <= 1'b0;
              state      <= WAIT_PROC;
            end else begin
              beat_cnt <= beat_cnt + 13'd1;
            end
          end
        end

        WAIT_PROC: begin
          if (row_done) begin
            row_ready <= 1'b0;
            mem_req   <= 1'b1;
            state     <= STORE;
          end
        end

        STORE: begin
          // The window engine produces one pixel fewer than it consumed.
          if (mem_ack) begin
            if (beat_cnt == width_q - 13'd2) begin
              beat_cnt   <= 13'd0;
              mem_req    <= 1'b0;
              sram_mode  <= 1'b1;
              sdram_mode <= 1'b1;
              state      <= NEXT;
            end else begin
              beat_cnt <= beat_cnt + 13'd1;
            end
          end
        end

        NEXT: begin
          row_cnt <= row_cnt + 13'd1;
          if (row_cnt + 13'd1 == height_q) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            mem_req <= 1'b1;
            state   <= LOAD;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

`ifdef TRANSFER_TIMEOUT_EN
        ERR: begin
          state <= ERR;
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase

`ifdef TRANSFER_TIMEOUT_EN
      // A request left unanswered for 255 cycles is treated as a dead memory.
      if (mem_req && !mem_ack) begin
        if (wd_cnt == 8'd254) begin
          wd_cnt     <= 8'd255;
          state      <= ERR;
          mem_req    <= 1'b0;
          err        <= 1'b1;
          busy       <= 1'b1;
          row_ready  <= 1'b0;
          sram_mode  <= 1'b1;
          sdram_mode <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 8'd1;
        end
      end else begin
        wd_cnt <= 8'd0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_row_transfer_ctrl.sv
// tb_row_transfer_ctrl: randomized and directed frames for row_transfer_ctrl,
// compared every cycle against a phase/countdown model of the frame protocol.
// Honours TRANSFER_TIMEOUT_EN the same way as the design.
module tb_row_transfer_ctrl;

  localparam int P_IDLE  = 0;
  localparam int P_INIT  = 1;
  localparam int P_LOAD  = 2;
  localparam int P_WAIT  = 3;
  localparam int P_STORE = 4;
  localparam int P_NEXT  = 5;
  localparam int P_DONE  = 6;
  localparam int P_ERR   = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [12:0] image_width = 13'd0;
  logic [12:0] image_height = 13'd0;
  logic        mem_ack = 1'b0;
  logic        row_done = 1'b0;
  logic        mem_req, sram_mode, sdram_mode, update, start_flag;
  logic        row_ready, busy, frame_done, err;

  int asserts = 0;
  int failures = 0;

  // reference model state: phase, beats still owed, rows still owed
  int   m_phase = P_IDLE;
  int   m_w = 0;
  int   m_h = 0;
  int   m_left = 0;
  int   m_rows_left = 0;
  int   m_stall = 0;
  logic m_upd = 1'b0;
  logic m_req;

  // stimulus knobs
  int ack_mode = 0;
  int rd_delay = 0;
  int wait_cnt = 0;
  int cyc_no = 0;
  bit rd_in_load = 0;
  bit start_in_load = 0;
  bit stray = 0;

  // observed statistics
  int   load_upd = 0;
  int   store_upd = 0;
  int   start_flags = 0;
  int   frames = 0;
  int   ready_rises = 0;
  int   ready_cycles = 0;
  logic prev_sram = 1'b1;
  logic prev_ready = 1'b0;

  int b_load, b_store, b_flags, b_frames, b_rises, b_rcycles;

  row_transfer_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .image_width  (image_width),
    .image_height (image_height),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .sram_mode    (sram_mode),
    .sdram_mode   (sdram_mode),
    .update       (update),
    .start_flag   (start_flag),
    .row_ready    (row_ready),
    .row_done     (row_done),
    .busy         (busy),
    .frame_done   (frame_done),
    .err          (err)
  );

  always #5 clk = ~clk;

  assign m_req = (m_phase == P_LOAD) || (m_phase == P_STORE);

  // Behavioural model: a frame is rows of (W loads, handover, W-1 stores).
  always @(posedge clk) begin
    if (rst) begin
      m_phase <= P_IDLE;
      m_upd   <= 1'b0;
      m_stall <= 0;
    end else begin
      m_upd <= m_req && mem_ack;
      case (m_phase)
        P_IDLE:
          if (start && image_width >= 2 && image_height >= 1) begin
            m_w     <= int'(image_width);
            m_h     <= int'(image_height);
            m_phase <= P_INIT;
          end
        P_INIT: begin
          m_left      <= m_w;
          m_rows_left <= m_h;
          m_phase     <= P_LOAD;
        end
        P_LOAD:
          if (mem_ack) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_phase <= P_WAIT;
          end
        P_WAIT:
          if (row_done) begin
            m_left  <= m_w - 1;
            m_phase <= P_STORE;
          end
        P_STORE:
          if (mem_ack) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_phase <= P_NEXT;
          end
        P_NEXT: begin
          m_rows_left <= m_rows_left - 1;
          if (m_rows_left == 1) m_phase <= P_DONE;
          else begin
            m_left  <= m_w;
            m_phase <= P_LOAD;
          end
        end
        P_DONE: m_phase <= P_IDLE;
        default: m_phase <= m_phase;
      endcase
`ifdef TRANSFER_TIMEOUT_EN
      if (m_req && !mem_ack) begin
        m_stall <= m_stall + 1;
        if (m_stall == 254) m_phase <= P_ERR;
      end else begin
        m_stall <= 0;
      end
`endif
    end
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, plus statistics gathering.
  task automatic check_output();
    check_bit("mem_req", mem_req, m_req);
    check_bit("sram_mode", sram_mode, !(m_phase == P_WAIT || m_phase == P_STORE));
    check_bit("sdram_mode", sdram_mode, !(m_phase == P_WAIT || m_phase == P_STORE));
    check_bit("update", update, m_upd);
    check_bit("start_flag", start_flag, m_phase == P_INIT);
    check_bit("row_ready", row_ready, m_phase == P_WAIT);
    check_bit("busy", busy, m_phase != P_IDLE);
    check_bit("frame_done", frame_done, m_phase == P_DONE);
    check_bit("err", err, m_phase == P_ERR);
    if (update === 1'b1) begin
      if (prev_sram) load_upd++;
      else store_upd++;
    end
    if (start_flag === 1'b1) start_flags++;
    if (frame_done === 1'b1) frames++;
    if (row_ready === 1'b1 && !prev_ready) ready_rises++;
    if (row_ready === 1'b1) ready_cycles++;
    prev_sram  = sram_mode;
    prev_ready = row_ready;
  endtask

  // One clock: check this cycle's outputs, then drive the next cycle's inputs.
  task automatic apply_stimulus();
    @(negedge clk);
    check_output();
    @(posedge clk);
    #2;
    cyc_no++;
    case (ack_mode)
      0:       mem_ack = 1'b1;
      1:       mem_ack = (cyc_no % 3 == 0);
      2:       mem_ack = ($urandom_range(0, 1) == 1);
      default: mem_ack = 1'b0;
    endcase
    if (m_phase == P_WAIT) begin
      row_done = (wait_cnt == rd_delay);
      wait_cnt++;
    end else begin
      wait_cnt = 0;
      row_done = (rd_in_load && m_phase == P_LOAD) || (stray && $urandom_range(0, 4) == 0);
    end
    start = 1'b0;
    if (start_in_load && m_phase == P_LOAD) begin
      start       = 1'b1;
      image_width = 13'd3;
    end else if (stray && m_phase != P_IDLE && $urandom_range(0, 5) == 0) begin
      start        = 1'b1;
      image_width  = 13'($urandom_range(0, 40));
      image_height = 13'($urandom_range(0, 4));
    end
  endtask

  task automatic run_frame(input int w, input int h, input int budget);
    int n;
    image_width  = 13'(w);
    image_height = 13'(h);
    start = 1'b1;
    n = 0;
    do begin
      apply_stimulus();
      n++;
    end while (m_phase != P_IDLE && n < budget);
    check_int("frame_cycle_budget", (m_phase == P_IDLE) ? 1 : 0, 1);
    check_bit("frame_end_busy", busy, 1'b0);
    if (m_phase != P_IDLE) begin
      rst = 1'b1;
      repeat (3) apply_stimulus();
      rst = 1'b0;
    end
  endtask

  task automatic snap();
    b_load = load_upd; b_store = store_upd; b_flags = start_flags;
    b_frames = frames; b_rises = ready_rises; b_rcycles = ready_cycles;
  endtask

  task automatic check_reset_values(input string tag);
    check_bit({tag, "_mem_req"}, mem_req, 1'b0);
    check_bit({tag, "_update"}, update, 1'b0);
    check_bit({tag, "_start_flag"}, start_flag, 1'b0);
    check_bit({tag, "_row_ready"}, row_ready, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_frame_done"}, frame_done, 1'b0);
    check_bit({tag, "_err"}, err, 1'b0);
    check_bit({tag, "_sram_mode"}, sram_mode, 1'b1);
    check_bit({tag, "_sdram_mode"}, sdram_mode, 1'b1);
  endtask

  // Hard stop in case the bench itself gets stuck.
  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    @(posedge clk);
    #2;
    repeat (2) apply_stimulus();
    rst = 1'b0;
    check_reset_values("por");

    // width 4, height 2, ack always, row_done 5 cycles into row_ready
    ack_mode = 0; rd_delay = 5;
    snap();
    run_frame(4, 2, 200);
    check_int("r37_load_updates", load_upd - b_load, 8);
    check_int("r37_store_updates", store_upd - b_store, 6);
    check_int("r37_start_flags", start_flags - b_flags, 1);
    check_int("r37_frame_done", frames - b_frames, 1);
    check_int("r37_row_ready_periods", ready_rises - b_rises, 2);
    check_int("r37_row_ready_cycles", ready_cycles - b_rcycles, 12);

    // width 30, height 1, ack every third cycle
    ack_mode = 1; rd_delay = 2;
    snap();
    run_frame(30, 1, 400);
    check_int("r38_load_updates", load_upd - b_load, 30);
    check_int("r38_store_updates", store_upd - b_store, 29);
    check_int("r38_frame_done", frames - b_frames, 1);

    // degenerate starts are ignored
    ack_mode = 0; rd_delay = 0;
    snap();
    run_frame(1, 5, 10);
    run_frame(5, 0, 10);
    check_int("r39_bad_start_flags", start_flags - b_flags, 0);

    // start during LOAD is ignored
    snap();
    start_in_load = 1;
    run_frame(6, 1, 100);
    start_in_load = 0;
    check_int("r39_load_start_flags", start_flags - b_flags, 1);
    check_int("r39_load_updates", load_upd - b_load, 6);
    check_int("r39_store_updates", store_upd - b_store, 5);

    // row_done during LOAD, including the final ack cycle, is ignored
    rd_in_load = 1; rd_delay = 4;
    snap();
    run_frame(3, 1, 100);
    rd_in_load = 0;
    check_int("r40_row_ready_cycles", ready_cycles - b_rcycles, 5);
    check_int("r40_store_updates", store_upd - b_store, 2);

    // smallest legal width
    rd_delay = 0;
    snap();
    run_frame(2, 1, 50);
    check_int("min_width_store_updates", store_upd - b_store, 1);

    // reset held three cycles mid-LOAD, ack high throughout
    image_width = 13'd20; image_height = 13'd2; start = 1'b1;
    repeat (8) apply_stimulus();
    rst = 1'b1;
    repeat (3) apply_stimulus();
    check_reset_values("r36");
    rst = 1'b0;
    snap();
    run_frame(2, 1, 50);
    check_int("r36_restart_frames", frames - b_frames, 1);
    check_int("r36_restart_flags", start_flags - b_flags, 1);

    // widest row
    snap();
    run_frame(8191, 1, 20000);
    check_int("wide_load_updates", load_upd - b_load, 8191);
    check_int("wide_store_updates", store_upd - b_store, 8190);

    // randomized frames with stray starts and row_done pulses
    stray = 1; ack_mode = 2;
    for (int i = 0; i < 12; i++) begin
      int w, h;
      w = $urandom_range(2, 24);
      h = $urandom_range(1, 3);
      rd_delay = $urandom_range(0, 6);
      snap();
      run_frame(w, h, (2 * w + 20) * h * 4 + 50);
      check_int("rand_store_updates", store_upd - b_store, (w - 1) * h);
    end
    stray = 0;

    // memory never answers
    ack_mode = 3;
    image_width = 13'd5; image_height = 13'd1; start = 1'b1;
`ifdef TRANSFER_TIMEOUT_EN
    repeat (300) apply_stimulus();
    check_bit("stall_err", err, 1'b1);
    check_bit("stall_mem_req", mem_req, 1'b0);
    check_bit("stall_busy", busy, 1'b1);
`else
    repeat (1000) apply_stimulus();
    check_bit("stall_err", err, 1'b0);
    check_bit("stall_mem_req", mem_req, 1'b1);
    check_bit("stall_busy", busy, 1'b1);
`endif
    rst = 1'b1;
    repeat (3) apply_stimulus();
    rst = 1'b0;
    check_reset_values("final");
    apply_stimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
